// File: rtl/subs_layer_enc_seq.sv
// Sequential forward S-box layer: substitutes LANES nibbles per cycle, LSB-first, behind valid/ready ports.
// Optional build macro SBOX_INV_EN adds dec_i to select the inverse S-box per block.
module subs_layer_enc_seq #(
    parameter int SIZE  = 64,
    parameter int LANES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_data,
`ifdef SBOX_INV_EN
    input  logic            dec_i,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_data,
    output logic            busy
);

    localparam int NCYC = SIZE / (4 * LANES);
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [SIZE-1:0] data_q;
    logic [SIZE-1:0] data_d;
    logic            out_valid_q;
    logic            busy_q;
    logic            load;
`ifdef SBOX_INV_EN
    logic            dec_q;
`endif

    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        logic [3:0] y;
        y = 4'h0;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

`ifdef SBOX_INV_EN
    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        y = 4'h0;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  4'hF: y = 4'hA;
            default: y = 4'h0;
        endcase
        return y;
    endfunction
`endif

    // DONE accepts a new block only while the current result is being taken.
    assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign load     = in_valid & in_ready;

    always_comb begin
        data_d = data_q;
        for (int l = 0; l < LANES; l++) begin
`ifdef SBOX_INV_EN
            data_d[(int'(cnt_q) * LANES + l) * 4 +: 4] = dec_q ?
                sbox_inv(data_q[(int'(cnt_q) * LANES + l) * 4 +: 4]) :
                sbox_fwd(data_q[(int'(cnt_q) * LANES + l) * 4 +: 4]);
`else
            data_d[(int'(cnt_q) * LANES + l) * 4 +: 4] =
                sbox_fwd(data_q[(int'(cnt_q) * LANES + l) * 4 +: 4]);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SBOX_INV_EN
            dec_q       <= 1'b0;
`endif
        end else if (load) begin
            state_q     <= BUSY;
            cnt_q       <= '0;
            data_q      <= in_data;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
`ifdef SBOX_INV_EN
            dec_q       <= dec_i;
`endif
        end else begin
            case (state_q)
                IDLE: ;
                BUSY: begin
                    data_q <= data_d;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= DONE;
                        cnt_q       <= '0;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_subs_layer_enc_seq.sv
// Scoreboard bench for subs_layer_enc_seq: 64-bit/4-lane instance plus a 128-bit/32-lane (single-cycle) instance.
module tb_subs_layer_enc_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         dec;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [63:0]  in_data, out_data;
    logic         v1_in_valid, v1_in_ready, v1_out_valid, v1_out_ready, v1_busy;
    logic [127:0] v1_in_data, v1_out_data;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];
    logic [127:0] exp1_q[$];

    subs_layer_enc_seq #(.SIZE(64), .LANES(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef SBOX_INV_EN
        .dec_i(dec),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    subs_layer_enc_seq #(.SIZE(128), .LANES(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v1_in_valid), .in_ready(v1_in_ready), .in_data(v1_in_data),
`ifdef SBOX_INV_EN
        .dec_i(dec),
`endif
        .out_valid(v1_out_valid), .out_ready(v1_out_ready), .out_data(v1_out_data), .busy(v1_busy)
    );

    function automatic logic [3:0] sb(input logic [3:0] x, input logic inv);
        logic [3:0] y;
        y = 4'h0;
        if (!inv) begin
            case (x)
                4'h0: y = 4'hC; 4'h1: y = 4'h5; 4'h2: y = 4'h6; 4'h3: y = 4'hB;
                4'h4: y = 4'h9; 4'h5: y = 4'h0; 4'h6: y = 4'hA; 4'h7: y = 4'hD;
                4'h8: y = 4'h3; 4'h9: y = 4'hE; 4'hA: y = 4'hF; 4'hB: y = 4'h8;
                4'hC: y = 4'h4; 4'hD: y = 4'h7; 4'hE: y = 4'h1; default: y = 4'h2;
            endcase
        end else begin
            case (x)
                4'h0: y = 4'h5; 4'h1: y = 4'hE; 4'h2: y = 4'hF; 4'h3: y = 4'h8;
                4'h4: y = 4'hC; 4'h5: y = 4'h1; 4'h6: y = 4'h2; 4'h7: y = 4'hD;
                4'h8: y = 4'hB; 4'h9: y = 4'h4; 4'hA: y = 4'h6; 4'hB: y = 4'h3;
                4'hC: y = 4'h0; 4'hD: y = 4'h7; 4'hE: y = 4'h9; default: y = 4'hA;
            endcase
        end
        return y;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input int nn, input logic inv);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < nn; i++) r[i*4 +: 4] = sb(d[i*4 +: 4], inv);
        return r;
    endfunction

    // Drive one block into the 64-bit instance; returns at accept edge + 1.
    task automatic put(input logic [63:0] d, input logic [63:0] e);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        exp_q.push_back({64'h0, e});
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL put_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b b=%0b d=%h required 0 0 0", out_valid, busy, out_data);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%0b v=%0b b=%0b required 1 0 0", in_ready, out_valid, busy);
        end
        checks++;
        if (v1_in_ready !== 1'b1 || v1_out_valid !== 1'b0 || v1_out_data !== 128'h0) begin
            errors++;
            $display("FAIL reset_v1 got rdy=%0b v=%0b d=%h", v1_in_ready, v1_out_valid, v1_out_data);
        end
    endtask

    task automatic test_vectors();
        logic [63:0] d, e;
        logic [127:0] ex;
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            if (t == 0) begin d = 64'h0; e = 64'hCCCCCCCCCCCCCCCC; end
            else if (t == 1) begin d = 64'h0123456789ABCDEF; e = 64'hC56B90AD3EF84712; end
            else begin d = {$urandom, $urandom}; ex = model({64'h0, d}, 16, 1'b0); e = ex[63:0]; end
            put(d, e);
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL accept_state t=%0d got b=%0b v=%0b required 1 0", t, busy, out_valid);
            end
            for (int k = 1; k <= 4; k++) begin
                @(posedge clk); #1;
                checks++;
                if (out_valid !== (k == 4)) begin
                    errors++;
                    $display("FAIL latency t=%0d cycle=%0d got v=%0b required %0b", t, k, out_valid, k == 4);
                end
            end
            ex = exp_q.pop_front();
            checks++;
            if (out_data !== ex[63:0]) begin
                errors++;
                $display("FAIL vector t=%0d got %h required %h", t, out_data, ex[63:0]);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL after_accept t=%0d got v=%0b b=%0b rdy=%0b required 0 0 1", t, out_valid, busy, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0]  d;
        logic [127:0] ex;
        int n;
        out_ready = 1'b0;
        d = {$urandom, $urandom};
        ex = model({64'h0, d}, 16, 1'b0);
        put(d, ex[63:0]);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL bp_timeout got v=%0b required 1", out_valid);
        end
        ex = exp_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== ex[63:0] || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold i=%0d got v=%0b d=%h rdy=%0b required 1 %h 0", i, out_valid, out_data, in_ready, ex[63:0]);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready got rdy=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got v=%0b b=%0b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d[3];
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) d[i] = {$urandom, $urandom};
        fork
            begin
                logic [127:0] ex;
                for (int i = 0; i < 3; i++) begin
                    int n;
                    in_data  = d[i];
                    in_valid = 1'b1;
                    ex = model({64'h0, d[i]}, 16, 1'b0);
                    exp_q.push_back(ex);
                    n = 0;
                    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                int got, cyc;
                logic pend, in_busy_test;
                logic [127:0] ex;
                got = 0; cyc = 0; pend = 1'b0;
                while (got < 3 && cyc < 100) begin
                    @(posedge clk); #1; cyc++;
                    if (pend) begin
                        in_busy_test = busy;
                        checks++;
                        if (in_busy_test !== 1'b1) begin
                            errors++;
                            $display("FAIL b2b_bubble got busy=%0b required 1", busy);
                        end
                        pend = 1'b0;
                    end
                    if (out_valid) begin
                        ex = exp_q.pop_front();
                        checks++;
                        if (out_data !== ex[63:0]) begin
                            errors++;
                            $display("FAIL b2b_data n=%0d got %h required %h", got, out_data, ex[63:0]);
                        end
                        got++;
                        pend = (got < 3);
                    end
                end
                checks++;
                if (got != 3) begin
                    errors++;
                    $display("FAIL b2b_count got %0d required 3", got);
                end
            end
        join
    endtask

    task automatic test_reset_mid_busy();
        logic [127:0] ex;
        int n;
        out_ready = 1'b1;
        put(64'hDEADBEEF01234567, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 64'h0) begin
            errors++;
            $display("FAIL rst_busy got v=%0b b=%0b d=%h required 0 0 0", out_valid, busy, out_data);
        end
        void'(exp_q.pop_front());
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_emit i=%0d got v=%0b required 0", i, out_valid);
            end
        end
        put(64'h0123456789ABCDEF, 64'hC56B90AD3EF84712);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        ex = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== ex[63:0]) begin
            errors++;
            $display("FAIL rst_recover got v=%0b d=%h required 1 %h", out_valid, out_data, ex[63:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ncyc1();
        logic [127:0] d, ex;
        int n;
        v1_out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin d = 128'h0; ex = {32{4'hC}}; end
            else begin d = {$urandom, $urandom, $urandom, $urandom}; ex = model(d, 32, 1'b0); end
            v1_in_data  = d;
            v1_in_valid = 1'b1;
            exp1_q.push_back(ex);
            n = 0;
            while (!v1_in_ready && n < 100) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
            v1_in_valid = 1'b0;
            checks++;
            if (v1_busy !== 1'b1 || v1_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL ncyc1_busy t=%0d got b=%0b v=%0b required 1 0", t, v1_busy, v1_out_valid);
            end
            @(posedge clk); #1;
            ex = exp1_q.pop_front();
            checks++;
            if (v1_out_valid !== 1'b1 || v1_busy !== 1'b0 || v1_out_data !== ex) begin
                errors++;
                $display("FAIL ncyc1_out t=%0d got v=%0b d=%h required 1 %h", t, v1_out_valid, v1_out_data, ex);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef SBOX_INV_EN
    task automatic test_inverse();
        logic [127:0] ex;
        int n;
        out_ready = 1'b1;
        dec = 1'b1;
        put(64'hC56B90AD3EF84712, 64'h0123456789ABCDEF);
        dec = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        ex = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== ex[63:0]) begin
            errors++;
            $display("FAIL inverse got v=%0b d=%h required 1 %h", out_valid, out_data, ex[63:0]);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        dec = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        v1_in_valid = 1'b0; v1_in_data = '0; v1_out_ready = 1'b1;
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        test_ncyc1();
`ifdef SBOX_INV_EN
        test_inverse();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
